// File: rtl/ether_tx_pkg.sv
// ether_tx_pkg: transmitter command codes, frame limits and feeder states (S_PAD exists only with ETXF_PAD_EN)
package ether_tx_pkg;
  localparam logic [3:0] ETX_CMD_SETSIZE = 4'd1;
  localparam logic [3:0] ETX_CMD_SETDATA = 4'd2;
  localparam logic [3:0] ETX_CMD_SEND = 4'd3;
  localparam logic [3:0] ETX_CMD_SETXOR = 4'd4;
  localparam int MIN_FRAME_WORDS = 15;
  typedef enum logic [2:0] {
    S_INIT,
    S_COLLECT,
    S_WRWORD,
    S_SIZE,
`ifdef ETXF_PAD_EN
    S_SEND,
    S_PAD
`else
    S_SEND
`endif
  } feeder_state_t;
endpackage

// File: rtl/etx_cmd_issuer.sv
// etx_cmd_issuer: toggle-ready command handshake with strobe holdoff between commands
module etx_cmd_issuer #(
  parameter int CMD_HOLDOFF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] data,
  input  logic        etx_ready,
  output logic        etx_cs,
  output logic [3:0]  etx_cmd,
  output logic [31:0] etx_data,
  output logic        done
);
  logic       ref_q;
  logic [7:0] hold;
  assign done = etx_cs && (etx_ready != ref_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      etx_cs <= 1'b0;
      etx_cmd <= 4'd0;
      etx_data <= 32'd0;
      ref_q <= 1'b0;
      hold <= 8'd0;
    end else if (etx_cs) begin
      if (done) begin
        etx_cs <= 1'b0;
        hold <= 8'(CMD_HOLDOFF);
      end
    end else if (hold > 8'd1) begin
      hold <= hold - 8'd1;
    end else if (req) begin
      etx_cs <= 1'b1;
      etx_cmd <= cmd;
      etx_data <= data;
      ref_q <= etx_ready;
      hold <= 8'd0;
    end
endmodule

// File: rtl/ether_tx_feeder.sv
// ether_tx_feeder: packs a byte stream into 32-bit words and drives the MII transmitter command port (ETXF_PAD_EN pads short frames to 15 words)
module ether_tx_feeder
  import ether_tx_pkg::*;
#(
  parameter int MAX_WORDS = 380,
  parameter int CMD_HOLDOFF = 1
) (
  input  logic        etx_clk,
  input  logic        etx_rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        etx_cs,
  output logic [3:0]  etx_cmd,
  output logic [31:0] etx_data,
  input  logic        etx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err_oversize
);
  feeder_state_t state;
  logic [8:0]    wc;
  logic [1:0]    bi;
  logic [31:0]   pack;
  logic          last_q;
  logic          req;
  logic          done;
  logic          is_data;
  logic [3:0]    cmd;
  logic [31:0]   data;
`ifdef ETXF_PAD_EN
  assign is_data = state == S_WRWORD || state == S_PAD;
`else
  assign is_data = state == S_WRWORD;
`endif
  always_comb begin
    req = state != S_COLLECT;
    cmd = is_data ? ETX_CMD_SETDATA : state == S_SEND ? ETX_CMD_SEND : ETX_CMD_SETSIZE;
    data = state == S_WRWORD ? pack : state == S_SIZE ? {23'b0, wc} : 32'b0;
  end
  always_ff @(posedge etx_clk or negedge etx_rst_n)
    if (!etx_rst_n) begin
      state <= S_INIT;
      wc <= 9'd0;
      bi <= 2'd0;
      pack <= 32'd0;
      last_q <= 1'b0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_INIT:
          if (done) begin
            state <= S_COLLECT;
            wc <= 9'd0;
            bi <= 2'd0;
            in_ready <= 1'b1;
          end
        S_COLLECT:
          if (in_valid && in_ready) begin
            busy <= 1'b1;
            if (!busy) err_oversize <= 1'b0;
            if (wc == 9'(MAX_WORDS)) begin
              err_oversize <= 1'b1;
              if (in_last) begin
                state <= S_SIZE;
                in_ready <= 1'b0;
              end
            end else begin
              pack <= bi == 2'd0 ? 32'(in_data) : pack | (32'(in_data) << {bi, 3'b000});
              bi <= bi + 2'd1;
              last_q <= in_last;
              if (bi == 2'd3 || in_last) begin
                state <= S_WRWORD;
                in_ready <= 1'b0;
              end
            end
          end
        S_WRWORD:
          if (done) begin
            wc <= wc + 9'd1;
            bi <= 2'd0;
            if (!last_q) begin
              state <= S_COLLECT;
              in_ready <= 1'b1;
            end
`ifdef ETXF_PAD_EN
            else if (wc + 9'd1 < 9'(MIN_FRAME_WORDS)) state <= S_PAD;
`endif
            else state <= S_SIZE;
          end
`ifdef ETXF_PAD_EN
        S_PAD:
          if (done) begin
            wc <= wc + 9'd1;
            if (wc + 9'd1 >= 9'(MIN_FRAME_WORDS)) state <= S_SIZE;
          end
`endif
        S_SIZE:
          if (done) state <= S_SEND;
        S_SEND:
          if (done) begin
            frame_done <= 1'b1;
            busy <= 1'b0;
            state <= S_INIT;
          end
        default: state <= S_INIT;
      endcase
    end
  etx_cmd_issuer #(.CMD_HOLDOFF(CMD_HOLDOFF)) u_issuer (
    .clk(etx_clk),
    .rst_n(etx_rst_n),
    .req(req),
    .cmd(cmd),
    .data(data),
    .etx_ready(etx_ready),
    .etx_cs(etx_cs),
    .etx_cmd(etx_cmd),
    .etx_data(etx_data),
    .done(done)
  );
endmodule

// File: tb/tb_ether_tx_feeder.sv
// tb_ether_tx_feeder: directed frames against a command-list model and a toggling transmitter model
module tb_ether_tx_feeder;
  localparam int MAXW = 16;
  localparam int HOLD = 1;
`ifdef ETXF_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  logic clk = 1'b0;
  logic etx_rst_n, in_valid, in_last, in_ready, etx_cs, etx_ready, busy, frame_done, err_oversize;
  logic [7:0] in_data;
  logic [3:0] etx_cmd;
  logic [31:0] etx_data;
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int fd_cnt = 0;
  int nsetdata = 0;
  int low_cnt = 1000;
  logic prev_cs = 1'b0;
  logic served = 1'b0;
  logic slow = 1'b0;
  logic abort = 1'b0;
  logic [35:0] cap;
  logic [31:0] last_size;
  logic [31:0] mw [0:31];
  logic [35:0] expq [$];

  ether_tx_feeder #(.MAX_WORDS(MAXW), .CMD_HOLDOFF(HOLD)) dut (
    .etx_clk(clk),
    .etx_rst_n(etx_rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .etx_cs(etx_cs),
    .etx_cmd(etx_cmd),
    .etx_data(etx_data),
    .etx_ready(etx_ready),
    .busy(busy),
    .frame_done(frame_done),
    .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic build_expect(input int n, input int base);
    int nw;
    logic [31:0] w;
    nw = (n + 3) / 4;
    if (nw > MAXW) nw = MAXW;
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < n) w[8*k+:8] = 8'(base + 4 * i + k);
      mw[i] = w;
      expq.push_back({4'd2, w});
    end
    if (PAD)
      while (nw < 15) begin
        mw[nw] = 32'd0;
        expq.push_back({4'd2, 32'd0});
        nw++;
      end
    expq.push_back({4'd1, 32'(nw)});
    expq.push_back({4'd3, 32'd0});
    expq.push_back({4'd1, 32'd0});
  endtask

  task automatic send_frame(input int n, input int base);
    int t;
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      in_valid = 1'b1;
      in_data = 8'(base + i);
      in_last = i == n - 1;
      t = 0;
      while (!in_ready && !abort && t < 5000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 5000) begin
        chk("in_ready_timeout", 64'(t), 64'd0);
        break;
      end
      if (abort) break;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_frame(input int n, input int base, input int lit_size, input bit lit_err);
    int fd0, acc0, t;
    build_expect(n, base);
    fd0 = fd_cnt;
    acc0 = accepted;
    last_size = 32'hDEAD;
    send_frame(n, base);
    t = 0;
    while (!frame_done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("frame_done_timeout", 64'(t), 64'd0);
    repeat (10) @(negedge clk);
    chk("frame_done_count", 64'(fd_cnt - fd0), 64'd1);
    chk("bytes_accepted", 64'(accepted - acc0), 64'(n));
    chk("setsize_value", 64'(last_size), 64'(lit_size));
    chk("err_oversize", 64'(err_oversize), 64'(lit_err));
    chk("busy_idle", 64'(busy), 64'd0);
    chk("cmds_pending", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    etx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!etx_cs) served = 1'b0;
      else if (!served) begin
        served = 1'b1;
        repeat ((slow && etx_cmd == 4'd2) ? 200 : 26) @(negedge clk);
        etx_ready = ~etx_ready;
      end
    end
  end

  always @(negedge clk) begin
    if (!etx_rst_n) begin
      prev_cs = 1'b0;
      low_cnt = 1000;
    end else begin
      if (in_valid && in_ready) accepted++;
      if (frame_done) fd_cnt++;
      chk("cs_with_in_ready", 64'(etx_cs && in_ready), 64'd0);
      if (etx_cs && !prev_cs) begin
        chk("holdoff", 64'(low_cnt >= HOLD), 64'd1);
        cap = {etx_cmd, etx_data};
        if (etx_cmd == 4'd1 && busy) last_size = etx_data;
        if (etx_cmd == 4'd2) begin
          nsetdata++;
          chk("busy_during_data", 64'(busy), 64'd1);
        end
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %h expected none", cap);
        end else chk("cmd", 64'(cap), 64'(expq.pop_front()));
      end else if (etx_cs) chk("cmd_stable", 64'({etx_cmd, etx_data}), 64'(cap));
      low_cnt = etx_cs ? 0 : low_cnt + 1;
      prev_cs = etx_cs;
    end
  end

  initial begin
    int n_tab [6] = '{60, 61, 20, 80, 8, 9};
    int b_tab [6] = '{1, 1, 1, 1, 8'hA0, 8'h50};
    int s_tab [6] = '{15, 16, PAD ? 15 : 5, 16, PAD ? 15 : 2, PAD ? 15 : 3};
    bit e_tab [6] = '{0, 0, 0, 1, 0, 0};
    int t, ns0;
    etx_rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    in_last = 1'b0;
    expq.push_back({4'd1, 32'd0});
    @(negedge clk);
    chk("rst_cs", 64'(etx_cs), 64'd0);
    chk("rst_cmd", 64'(etx_cmd), 64'd0);
    chk("rst_data", 64'(etx_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(err_oversize), 64'd0);
    repeat (2) @(negedge clk);
    etx_rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 6; f++) begin
      slow = f == 5;
      run_frame(n_tab[f], b_tab[f], s_tab[f], e_tab[f]);
      if (f == 0) begin
        chk("model_first_word", 64'(mw[0]), 64'h04030201);
        chk("model_word14", 64'(mw[14]), 64'h3C3B3A39);
      end
      if (f == 1) chk("model_word15", 64'(mw[15]), 64'h0000003D);
    end
    slow = 1'b0;
    ns0 = nsetdata;
    build_expect(60, 1);
    fork
      send_frame(60, 1);
    join_none
    t = 0;
    while (!(etx_cs && etx_cmd == 4'd2 && nsetdata - ns0 >= 3) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("mid_setdata_timeout", 64'(t), 64'd0);
    #3;
    etx_rst_n = 1'b0;
    abort = 1'b1;
    #1;
    chk("async_rst_cs", 64'(etx_cs), 64'd0);
    expq.delete();
    repeat (40) @(negedge clk);
    abort = 1'b0;
    expq.push_back({4'd1, 32'd0});
    etx_rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(60, 1, 15, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
